// File: rtl/port_io_pkg.sv
// Shared constants for the port I/O hub: port addresses, PS/2 scan
// prefixes and the CRTC register indices that drive the cursor.
package port_io_pkg;

  localparam logic [15:0] P_KBD_DATA = 16'h0060;
  localparam logic [15:0] P_KBD_STAT = 16'h0064;
  localparam logic [15:0] P_CRTC_IDX = 16'h03D4;
  localparam logic [15:0] P_CRTC_DAT = 16'h03D5;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT0  = 8'hE0;
  localparam logic [7:0] SC_EXT1  = 8'hE1;

  localparam logic [7:0] CR_CUR_START = 8'h0A;
  localparam logic [7:0] CR_CUR_END   = 8'h0B;
  localparam logic [7:0] CR_CUR_HI    = 8'h0E;
  localparam logic [7:0] CR_CUR_LO    = 8'h0F;

  // Extended-key prefixes travel to the CPU untouched and keep the break state.
  function automatic logic is_ext_prefix(input logic [7:0] code);
    return (code == SC_EXT0) || (code == SC_EXT1);
  endfunction

endpackage

// File: rtl/port_io_hub_ps2_at2xt.sv
// AT scan set 2 to XT scan set 1 translator. Purely combinational;
// codes without an XT equivalent are passed through unchanged.
module ps2_at2xt (
  input  logic [7:0] at_code,
  output logic [7:0] xt_code
);

  // Lookup of the make code; the break bit is merged by the caller.
  always_comb begin
    xt_code = at_code;
    case (at_code)
      8'h01: xt_code = 8'h43;  8'h03: xt_code = 8'h3F;  8'h04: xt_code = 8'h3D;
      8'h05: xt_code = 8'h3B;  8'h06: xt_code = 8'h3C;  8'h07: xt_code = 8'h58;
      8'h09: xt_code = 8'h44;  8'h0A: xt_code = 8'h42;  8'h0B: xt_code = 8'h40;
      8'h0C: xt_code = 8'h3E;  8'h0D: xt_code = 8'h0F;  8'h0E: xt_code = 8'h29;
      8'h11: xt_code = 8'h38;  8'h12: xt_code = 8'h2A;  8'h14: xt_code = 8'h1D;
      8'h15: xt_code = 8'h10;  8'h16: xt_code = 8'h02;  8'h1A: xt_code = 8'h2C;
      8'h1B: xt_code = 8'h1F;  8'h1C: xt_code = 8'h1E;  8'h1D: xt_code = 8'h11;
      8'h1E: xt_code = 8'h03;  8'h21: xt_code = 8'h2E;  8'h22: xt_code = 8'h2D;
      8'h23: xt_code = 8'h20;  8'h24: xt_code = 8'h12;  8'h25: xt_code = 8'h05;
      8'h26: xt_code = 8'h04;  8'h29: xt_code = 8'h39;  8'h2A: xt_code = 8'h2F;
      8'h2B: xt_code = 8'h21;  8'h2C: xt_code = 8'h14;  8'h2D: xt_code = 8'h13;
      8'h2E: xt_code = 8'h06;  8'h31: xt_code = 8'h31;  8'h32: xt_code = 8'h30;
      8'h33: xt_code = 8'h23;  8'h34: xt_code = 8'h22;  8'h35: xt_code = 8'h15;
      8'h36: xt_code = 8'h07;  8'h3A: xt_code = 8'h32;  8'h3B: xt_code = 8'h24;
      8'h3C: xt_code = 8'h16;  8'h3D: xt_code = 8'h08;  8'h3E: xt_code = 8'h09;
      8'h41: xt_code = 8'h33;  8'h42: xt_code = 8'h25;  8'h43: xt_code = 8'h17;
      8'h44: xt_code = 8'h18;  8'h45: xt_code = 8'h0B;  8'h46: xt_code = 8'h0A;
      8'h49: xt_code = 8'h34;  8'h4A: xt_code = 8'h35;  8'h4B: xt_code = 8'h26;
      8'h4C: xt_code = 8'h27;  8'h4D: xt_code = 8'h19;  8'h4E: xt_code = 8'h0C;
      8'h52: xt_code = 8'h28;  8'h54: xt_code = 8'h1A;  8'h55: xt_code = 8'h0D;
      8'h58: xt_code = 8'h3A;  8'h59: xt_code = 8'h36;  8'h5A: xt_code = 8'h1C;
      8'h5B: xt_code = 8'h1B;  8'h5D: xt_code = 8'h2B;  8'h66: xt_code = 8'h0E;
      8'h69: xt_code = 8'h4F;  8'h6B: xt_code = 8'h4B;  8'h6C: xt_code = 8'h47;
      8'h70: xt_code = 8'h52;  8'h71: xt_code = 8'h53;  8'h72: xt_code = 8'h50;
      8'h73: xt_code = 8'h4C;  8'h74: xt_code = 8'h4D;  8'h75: xt_code = 8'h48;
      8'h76: xt_code = 8'h01;  8'h77: xt_code = 8'h45;  8'h78: xt_code = 8'h57;
      8'h79: xt_code = 8'h4E;  8'h7A: xt_code = 8'h51;  8'h7B: xt_code = 8'h4A;
      8'h7C: xt_code = 8'h37;  8'h7D: xt_code = 8'h49;  8'h7E: xt_code = 8'h46;
      8'h83: xt_code = 8'h41;
      default: xt_code = at_code;
    endcase
  end

endmodule

// File: rtl/port_io_hub.sv
// I/O port decoder: keyboard controller (60h/64h) fed by a translated
// PS/2 receive FIFO, plus the CRTC register file (3D4h/3D5h) that
// supplies cursor position and shape to the video unit.
module port_io_hub
  import port_io_pkg::*;
#(
  parameter int KBD_DEPTH = 16,
  parameter int CRTC_REGS = 32,
  parameter int CURSOR_W  = 11
) (
  input  logic                clock50,
  input  logic                reset,
  input  logic [15:0]         port_addr,
  output logic [15:0]         port_in,
  input  logic [15:0]         port_out,
  input  logic                port_bit,
  input  logic                port_clk,
  input  logic                port_read,
  input  logic [7:0]          ps2_data,
  input  logic                ps2_data_clk,
  output logic                kbd_irq,
  output logic [CURSOR_W-1:0] cursor,
  output logic [4:0]          cursor_start,
  output logic [4:0]          cursor_end,
  output logic                cursor_off
);

  localparam int AW = $clog2(KBD_DEPTH);
  localparam int IW = $clog2(CRTC_REGS);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(KBD_DEPTH);

  logic          read_prev, write_prev;
  logic          read_fall, write_fall;
  logic [7:0]    fifo_mem [KBD_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          overflow, brk;
  logic [7:0]    keyb_data;
  logic [7:0]    xt_code, push_byte;
  logic          is_break, is_ext, push_req, push_en, push_drop, pop_en, stat_rd;
  logic          fifo_empty, fifo_full;
  logic [7:0]    crtc [CRTC_REGS];
  logic [IW-1:0] crtc_index;
  logic          unused_bits;

  assign unused_bits = ^{port_bit, port_out[15:8]};

  ps2_at2xt u_xlate (
    .at_code (ps2_data),
    .xt_code (xt_code)
  );

  assign is_break   = (ps2_data == SC_BREAK);
  assign is_ext     = is_ext_prefix(ps2_data);
  assign push_byte  = is_ext ? ps2_data : (xt_code | {brk, 7'b0});
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign read_fall  = read_prev & ~port_read;
  assign write_fall = write_prev & ~port_clk;
  assign pop_en     = read_fall && (port_addr == P_KBD_DATA) && !fifo_empty;
  assign stat_rd    = read_fall && (port_addr == P_KBD_STAT);
  assign push_req   = ps2_data_clk && !is_break;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_en    = push_req && (!fifo_full || pop_en);
  assign push_drop  = push_req && !push_en;

  // Strobe history for falling-edge detection in the clock50 domain.
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      read_prev  <= 1'b0;
      write_prev <= 1'b0;
    end else begin
      read_prev  <= port_read;
      write_prev <= port_clk;
    end
  end

  // FIFO storage; contents are meaningless until count says otherwise.
  always_ff @(posedge clock50) begin
    if (push_en) fifo_mem[wr_ptr] <= push_byte;
  end

  // Keyboard controller state: pointers, occupancy, break latch, status.
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      brk       <= 1'b0;
      keyb_data <= 8'h00;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ps2_data_clk) begin
        if (is_break)     brk <= 1'b1;
        else if (!is_ext) brk <= 1'b0;
      end
      if (pop_en)       keyb_data <= fifo_mem[rd_ptr];
      else if (stat_rd) keyb_data <= {6'b0, overflow, !fifo_empty};
      if (push_drop)    overflow <= 1'b1;
      else if (stat_rd) overflow <= 1'b0;
    end
  end

  // CRTC index and register file, written on the port_clk falling edge.
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      crtc_index <= '0;
      for (int i = 0; i < CRTC_REGS; i++) crtc[i] <= 8'h00;
    end else if (write_fall) begin
      if (port_addr == P_CRTC_IDX)      crtc_index       <= port_out[IW-1:0];
      else if (port_addr == P_CRTC_DAT) crtc[crtc_index] <= port_out[7:0];
    end
  end

  // Read-data multiplexer, combinational on the current address.
  always_comb begin
    port_in = 16'h0000;
    case (port_addr)
      P_KBD_DATA, P_KBD_STAT: port_in = {8'h00, keyb_data};
      P_CRTC_IDX:             port_in = {8'h00, 8'(crtc_index)};
      P_CRTC_DAT:             port_in = {8'h00, crtc[crtc_index]};
      default:                port_in = 16'h0000;
    endcase
  end

  assign kbd_irq      = !fifo_empty;
  assign cursor       = CURSOR_W'({crtc[IW'(CR_CUR_HI)], crtc[IW'(CR_CUR_LO)]});
  assign cursor_start = crtc[IW'(CR_CUR_START)][4:0];
  assign cursor_end   = crtc[IW'(CR_CUR_END)][4:0];
  assign cursor_off   = crtc[IW'(CR_CUR_START)][5];

endmodule

// File: tb/tb_port_io_hub.sv
// Testbench for port_io_hub: directed vector table, hand-written corner
// sequences, and randomized keyboard traffic against a queue model.
module tb_port_io_hub;

  localparam int DEPTH = 16;
  localparam int OP_PS2 = 0;
  localparam int OP_RD  = 1;
  localparam int OP_WR  = 2;

  logic        clock50, reset;
  logic [15:0] port_addr, port_in, port_out;
  logic        port_bit, port_clk, port_read;
  logic [7:0]  ps2_data;
  logic        ps2_data_clk;
  logic        kbd_irq;
  logic [10:0] cursor;
  logic [4:0]  cursor_start, cursor_end;
  logic        cursor_off;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          op;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model of the keyboard side
  logic [7:0] kq[$];
  logic       m_brk, m_ovf;
  logic [7:0] m_kdata;

  logic [7:0] make_at [17] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                               8'h46, 8'h45, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h1C};
  logic [7:0] make_xt [17] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
                               8'h0A, 8'h0B, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h1E};
  logic [7:0] pool [12] = '{8'h1C, 8'h75, 8'h5A, 8'h29, 8'h0D, 8'h76, 8'h5F,
                            8'hF0, 8'hF0, 8'hE0, 8'hE1, 8'h16};

  port_io_hub dut (
    .clock50      (clock50),
    .reset        (reset),
    .port_addr    (port_addr),
    .port_in      (port_in),
    .port_out     (port_out),
    .port_bit     (port_bit),
    .port_clk     (port_clk),
    .port_read    (port_read),
    .ps2_data     (ps2_data),
    .ps2_data_clk (ps2_data_clk),
    .kbd_irq      (kbd_irq),
    .cursor       (cursor),
    .cursor_start (cursor_start),
    .cursor_end   (cursor_end),
    .cursor_off   (cursor_off)
  );

  initial begin
    clock50 = 1'b0;
    forever #5 clock50 = ~clock50;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Set 2 -> set 1 for the codes this bench sends; anything else is unchanged.
  function automatic logic [7:0] xlate(input logic [7:0] b);
    for (int i = 0; i < 17; i++) if (make_at[i] == b) return make_xt[i];
    case (b)
      8'h75: return 8'h48;
      8'h5A: return 8'h1C;
      8'h29: return 8'h39;
      8'h0D: return 8'h0F;
      8'h76: return 8'h01;
      default: return b;
    endcase
  endfunction

  function automatic void model_reset();
    kq.delete();
    m_brk = 1'b0; m_ovf = 1'b0; m_kdata = 8'h00;
  endfunction

  function automatic void model_push(input logic [7:0] v);
    if (kq.size() < DEPTH) kq.push_back(v);
    else m_ovf = 1'b1;
  endfunction

  function automatic void model_ps2(input logic [7:0] b);
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0 || b == 8'hE1) model_push(b);
    else begin
      model_push(xlate(b) | (m_brk ? 8'h80 : 8'h00));
      m_brk = 1'b0;
    end
  endfunction

  function automatic void model_read(input logic [15:0] addr);
    if (addr == 16'h0060) begin
      if (kq.size() > 0) m_kdata = kq.pop_front();
    end else if (addr == 16'h0064) begin
      m_kdata = {6'b0, m_ovf, kq.size() != 0};
      m_ovf = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clock50);
    #1;
  endtask

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ps2_send(input logic [7:0] b);
    ps2_data = b;
    ps2_data_clk = 1'b1;
    tick();
    ps2_data_clk = 1'b0;
    model_ps2(b);
  endtask

  task automatic io_read(input logic [15:0] addr, output logic [15:0] val);
    port_addr = addr;
    port_read = 1'b1;
    tick();
    port_read = 1'b0;
    tick();
    model_read(addr);
    val = port_in;
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [15:0] data);
    port_addr = addr;
    port_out  = data;
    port_clk  = 1'b1;
    tick();
    port_clk  = 1'b0;
    tick();
  endtask

  // Keyboard read checked against the model, including the IRQ level.
  task automatic rd_check(input logic [15:0] addr, input string name);
    logic [15:0] v;
    io_read(addr, v);
    check_output(name, v, {8'h00, m_kdata});
    check_output({name, "_irq"}, {15'b0, kbd_irq}, {15'b0, kq.size() != 0});
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic apply_stimulus();
    logic [15:0] v;
    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_PS2: ps2_send(vecs[i].data[7:0]);
        OP_WR:  io_write(vecs[i].addr, vecs[i].data);
        default: begin
          io_read(vecs[i].addr, v);
          check_output($sformatf("vec%0d_rd_%h", i, vecs[i].addr), v, vecs[i].exp);
        end
      endcase
    end
  endtask

  initial begin
    logic [15:0] v;
    reset = 1'b1;
    port_addr = 16'h0000; port_out = 16'h0000; port_bit = 1'b0;
    port_clk = 1'b0; port_read = 1'b0; ps2_data = 8'h00; ps2_data_clk = 1'b0;
    model_reset();
    repeat (3) @(posedge clock50);
    #1;
    reset = 1'b0;

    // Reset state
    port_addr = 16'h0060;
    #1;
    check_output("rst_port60", port_in, 16'h0000);
    check_output("rst_irq", {15'b0, kbd_irq}, 16'h0000);
    check_output("rst_cursor", {5'b0, cursor}, 16'h0000);
    check_output("rst_cstart", {11'b0, cursor_start}, 16'h0000);
    check_output("rst_cend", {11'b0, cursor_end}, 16'h0000);
    check_output("rst_coff", {15'b0, cursor_off}, 16'h0000);

    // Directed vector table
    vecs.push_back(vec_t'{OP_RD,  16'h0064, 16'h0000, 16'h0000});
    vecs.push_back(vec_t'{OP_PS2, 16'h0000, 16'h001C, 16'h0000});
    vecs.push_back(vec_t'{OP_RD,  16'h0064, 16'h0000, 16'h0001});
    vecs.push_back(vec_t'{OP_PS2, 16'h0000, 16'h00F0, 16'h0000});
    vecs.push_back(vec_t'{OP_PS2, 16'h0000, 16'h001C, 16'h0000});
    vecs.push_back(vec_t'{OP_RD,  16'h0060, 16'h0000, 16'h001E});
    vecs.push_back(vec_t'{OP_RD,  16'h0060, 16'h0000, 16'h009E});
    vecs.push_back(vec_t'{OP_RD,  16'h0064, 16'h0000, 16'h0000});
    vecs.push_back(vec_t'{OP_PS2, 16'h0000, 16'h00E0, 16'h0000});
    vecs.push_back(vec_t'{OP_PS2, 16'h0000, 16'h0075, 16'h0000});
    vecs.push_back(vec_t'{OP_PS2, 16'h0000, 16'h00E0, 16'h0000});
    vecs.push_back(vec_t'{OP_PS2, 16'h0000, 16'h00F0, 16'h0000});
    vecs.push_back(vec_t'{OP_PS2, 16'h0000, 16'h0075, 16'h0000});
    vecs.push_back(vec_t'{OP_RD,  16'h0060, 16'h0000, 16'h00E0});
    vecs.push_back(vec_t'{OP_RD,  16'h0060, 16'h0000, 16'h0048});
    vecs.push_back(vec_t'{OP_RD,  16'h0060, 16'h0000, 16'h00E0});
    vecs.push_back(vec_t'{OP_RD,  16'h0060, 16'h0000, 16'h00C8});
    vecs.push_back(vec_t'{OP_RD,  16'h0060, 16'h0000, 16'h00C8});
    vecs.push_back(vec_t'{OP_WR,  16'h03D4, 16'h000E, 16'h0000});
    vecs.push_back(vec_t'{OP_WR,  16'h03D5, 16'h0007, 16'h0000});
    vecs.push_back(vec_t'{OP_WR,  16'h03D4, 16'h000F, 16'h0000});
    vecs.push_back(vec_t'{OP_WR,  16'h03D5, 16'h00D0, 16'h0000});
    vecs.push_back(vec_t'{OP_RD,  16'h03D5, 16'h0000, 16'h00D0});
    vecs.push_back(vec_t'{OP_RD,  16'h03D4, 16'h0000, 16'h000F});
    vecs.push_back(vec_t'{OP_WR,  16'h03D4, 16'h000A, 16'h0000});
    vecs.push_back(vec_t'{OP_WR,  16'h03D5, 16'h0026, 16'h0000});
    vecs.push_back(vec_t'{OP_RD,  16'h03D5, 16'h0000, 16'h0026});
    vecs.push_back(vec_t'{OP_RD,  16'h03D4, 16'h0000, 16'h000A});
    vecs.push_back(vec_t'{OP_WR,  16'h1234, 16'h00FF, 16'h0000});
    vecs.push_back(vec_t'{OP_RD,  16'h1234, 16'h0000, 16'h0000});
    apply_stimulus();

    check_output("cursor_pos", {5'b0, cursor}, 16'h07D0);
    check_output("cursor_off", {15'b0, cursor_off}, 16'h0001);
    check_output("cursor_start", {11'b0, cursor_start}, 16'h0006);
    io_write(16'h03D4, 16'h000B);
    io_write(16'h03D5, 16'h00EF);
    check_output("cursor_end", {11'b0, cursor_end}, 16'h000F);

    // Overflow: 17 make codes, nothing read
    for (int i = 0; i < 17; i++) ps2_send(make_at[i]);
    io_read(16'h0064, v);
    check_output("ovf_stat1", v, 16'h0003);
    io_read(16'h0064, v);
    check_output("ovf_stat2", v, 16'h0001);
    for (int i = 0; i < 16; i++) begin
      io_read(16'h0060, v);
      check_output($sformatf("ovf_pop%0d", i), v, {8'h00, make_xt[i]});
    end
    io_read(16'h0060, v);
    check_output("ovf_pop_hold", v, {8'h00, make_xt[15]});
    check_output("ovf_irq_empty", {15'b0, kbd_irq}, 16'h0000);

    // Push into a full FIFO coinciding with a pop
    for (int i = 0; i < 16; i++) ps2_send(make_at[i]);
    port_addr = 16'h0060;
    port_read = 1'b1;
    tick();
    port_read = 1'b0;
    ps2_data = 8'h1C;
    ps2_data_clk = 1'b1;
    tick();
    ps2_data_clk = 1'b0;
    check_output("sim_pop", port_in, 16'h0002);
    model_read(16'h0060);
    model_ps2(8'h1C);
    io_read(16'h0064, v);
    check_output("sim_stat", v, 16'h0001);
    for (int i = 0; i < 16; i++) rd_check(16'h0060, $sformatf("sim_pop%0d", i));
    check_output("sim_last", {8'h00, m_kdata}, 16'h001E);

    // Reset with bytes queued and a break pending
    for (int i = 0; i < 5; i++) ps2_send(make_at[i]);
    ps2_send(8'hF0);
    pulse_reset();
    check_output("rst2_irq", {15'b0, kbd_irq}, 16'h0000);
    check_output("rst2_cursor", {5'b0, cursor}, 16'h0000);
    io_read(16'h0064, v);
    check_output("rst2_stat", v, 16'h0000);
    ps2_send(8'h1C);
    io_read(16'h0060, v);
    check_output("rst2_make", v, 16'h001E);

    // Randomized keyboard traffic against the model
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        ps2_send(pool[$urandom_range(0, 11)]);
        check_output($sformatf("rnd%0d_irq", n), {15'b0, kbd_irq}, {15'b0, kq.size() != 0});
      end else if (r < 9) begin
        rd_check(16'h0060, $sformatf("rnd%0d_rd60", n));
      end else begin
        rd_check(16'h0064, $sformatf("rnd%0d_rd64", n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
